round_scheduler: RTL

ROUND_SCHEDULER -- requirements
Module: round_scheduler

---
 rtl/round_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/round_scheduler.sv
// Reaction-game round sequencer: picks a target button, waits for release, scores the
// response within a window, pauses, and repeats until the game timer expires.
module round_scheduler #(
  parameter int unsigned GAP_CYCLES    = 5000000,
  parameter int unsigned WINDOW_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] buttons,
  input  logic [2:0] rand_idx,
  input  logic       time_up,
  output logic       prng_en,
  output logic       timer_start,
  output logic [2:0] prompt,
  output logic       prompt_valid,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       game_over
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StPick,
    StRelease,
    StPrompt,
    StGap,
    StDone
  } state_t;

  localparam logic [31:0] WinLast = 32'(WINDOW_CYCLES - 1);
  localparam logic [31:0] GapLast = 32'(GAP_CYCLES - 1);
  localparam logic [7:0]  MaxCnt  = 8'd99;

  state_t      state;
  logic [31:0] cnt;
  logic [7:0]  target;
  logic        running;

  assign target  = 8'd1 << prompt;
  assign running = (state == StArm) || (state == StPick) || (state == StRelease) ||
                   (state == StPrompt) || (state == StGap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      cnt          <= '0;
      prng_en      <= 1'b0;
      timer_start  <= 1'b0;
      prompt       <= '0;
      prompt_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      score        <= '0;
      misses       <= '0;
      game_over    <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      // Timer expiry pre-empts any scoring event in the same cycle.
      if (time_up && running) begin
        state        <= StDone;
        prng_en      <= 1'b0;
        timer_start  <= 1'b0;
        prompt_valid <= 1'b0;
        game_over    <= 1'b1;
      end else begin
        case (state)
          StIdle: begin
            if (start) begin
              state       <= StArm;
              score       <= '0;
              misses      <= '0;
              prng_en     <= 1'b1;
              timer_start <= 1'b1;
            end
          end
          StArm: state <= StPick;
          StPick: begin
            prompt <= rand_idx;
            state  <= StRelease;
          end
          StRelease: begin
            if (buttons == 8'h00) begin
              state        <= StPrompt;
              prompt_valid <= 1'b1;
              cnt          <= '0;
            end
          end
          StPrompt: begin
            if (buttons == target) begin
              hit          <= 1'b1;
              score        <= (score == MaxCnt) ? MaxCnt : score + 8'd1;
              prompt_valid <= 1'b0;
              cnt          <= '0;
              state        <= StGap;
            end else if (buttons != 8'h00 || cnt == WinLast) begin
              miss         <= 1'b1;
              misses       <= (misses == MaxCnt) ? MaxCnt : misses + 8'd1;
              prompt_valid <= 1'b0;
              cnt          <= '0;
              state        <= StGap;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          StGap: begin
            if (cnt == GapLast) begin
              state <= StPick;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          StDone:  state <= StDone;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
